ew_state_reader: RTL and testbench
==================================

Name: ew_state_reader

Overview:
- Read-out end of the EW state memory: the EW update writes state vectors s[addr]; this block reads them back and streams them out.
- On a start command it reads a contiguous, wrap-around address range from the state RAM read port (synchronous, 1-cycle latency).
- Emits one TILE_SIZE vector per beat on an AXIS-style master with TLAST, and fully honours backpressure.
- Used for state dump and checkpointing between sequences.

Parameters:
- TILE_SIZE, 4, lanes per vector.
- DATA_WIDTH, 16, bits per lane, signed Q-format state.
- S_ADDR_W, 6, state RAM address width; depth = 2^S_ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  S_ADDR_W  first address; sampled with start.
- len  in  S_ADDR_W  beat count; 0 means full depth 2^S_ADDR_W.
- busy  out  1  high from the cycle after start is accepted until the last beat handshakes.
- done  out  1  one-cycle pulse in the cycle after the last beat handshakes.
- rd_en  out  1  state RAM read strobe.
- rd_addr  out  S_ADDR_W  state RAM read address.
- rd_data  in  signed DATA_WIDTH x TILE_SIZE  read data, valid one cycle after rd_en.
- m_axis_TVALID  out  1  output beat valid.
- m_axis_TREADY  in  1  consumer ready.
- m_axis_TDATA  out  signed DATA_WIDTH x TILE_SIZE  output vector.
- m_axis_TLAST  out  1  marks the final beat of the range.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_axis_TVALID=0, m_axis_TLAST=0, m_axis_TDATA all 0. Buffer emptied, counters cleared, FSM in IDLE.
- Reset asserted mid-run aborts immediately. No further rd_en and no partial-beat output after reset release.
- FSM states:
  - IDLE: start=1 latches base_addr and len (issue counter rem = len, 0 maps to 2^S_ADDR_W) and goes to RUN.
  - RUN: issues reads. When the last read is issued, goes to DRAIN.
  - DRAIN: waits for buffered and in-flight beats. When the TLAST beat handshakes, goes to IDLE and pulses done in the following cycle.
- start in RUN or DRAIN is ignored; latched parameters are unaffected.
- Address arithmetic:
  - rd_addr starts at base_addr and increments by 1 per issued read, modulo 2^S_ADDR_W (63 -> 0 at default).
  - Issue and beat counters are S_ADDR_W+1 bits wide.
- Buffer: a 2-entry vector FIFO captures rd_data in the cycle after rd_en. The FIFO head drives m_axis_TDATA and TVALID directly (registered).
- Issue rule:
  - rd_en=1 in RUN when count + inflight - pop < 2, where pop = TVALID & TREADY this cycle.
  - The buffer therefore never overflows, and throughput is 1 beat/cycle with TREADY held high.
- Latency: start accepted in cycle T → first rd_en in T+1 → data captured at the end of T+2 → first TVALID in T+3.
- AXIS rules:
  - TVALID, once high, stays high with stable TDATA and TLAST until the handshake.
  - TLAST=1 only on beat number len (counted by a separate beat counter at output).
- Simultaneous capture and pop: the FIFO count is unchanged and ordering is preserved.
- Back-to-back: start may be accepted in the IDLE cycle immediately after done-transition. The new range's first TVALID is no earlier than T+3.
- Data is passed through unmodified, bit-exact.

Optional Feature:
- Macro: EW_STATE_RD_CLEAR_EN.
- Defined:
  - Adds output ports wr_en (1), wr_addr (S_ADDR_W) and wr_data (DATA_WIDTH x TILE_SIZE, tied to 0).
  - Clear-on-read: wr_en pulses one cycle after each rd_en, with wr_addr equal to the address read in the previous cycle.
  - Used to zero state between sequences.
  - Write ports reset to 0.
- Undefined: ports absent; the RAM is never written by this block.

Decomposition:
- Package ew_state_pkg:
  - default TILE_SIZE, DATA_WIDTH and S_ADDR_W localparams;
  - typedef state_vec_t (signed lane array);
  - FSM enum {IDLE, RUN, DRAIN}.
- Sub-module vec_skid2: 2-entry vector FIFO with push, pop and count, reused by other EW-side streams.

Test Plan:
- base=0, len=4, TREADY=1, RAM[a]=a*16+lane → beats 0..3 on consecutive cycles starting T+3; TLAST on beat 4; done one cycle later; rd_en high for exactly 4 cycles.
- base=62, len=4 (S_ADDR_W=6) → rd_addr sequence 62, 63, 0, 1; data matches those addresses in order.
- len=0 → exactly 64 beats; TLAST only on beat 64; busy high throughout.
- len=8 with TREADY low cycles 5-9 and alternating 1/0 afterwards → no lost or duplicated beats, TDATA stable while stalled, rd_en deasserts while the FIFO is full.
- start pulsed again mid-run with base=10 → ignored; original range completes unchanged.
- rst_n low mid-run at beat 3 of 8 → all outputs 0; a new start of base=5, len=2 then yields exactly 2 correct beats. With EW_STATE_RD_CLEAR_EN defined: wr_en tracks rd_en by 1 cycle, and a reread returns zeros.

Source files
------------

// File: rtl/ew_state_pkg.sv
// Shared types and default geometry for the EW state memory read-out path.
package ew_state_pkg;

  localparam int unsigned TILE_SIZE  = 4;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned S_ADDR_W   = 6;
  localparam int unsigned CNT_W      = S_ADDR_W + 1;
  localparam int unsigned VEC_W      = TILE_SIZE * DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] lane_t;
  typedef lane_t [TILE_SIZE-1:0] state_vec_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

  // A zero length request means the whole memory.
  function automatic logic [CNT_W-1:0] range_len(input logic [S_ADDR_W-1:0] len);
    range_len = (len == '0) ? {1'b1, S_ADDR_W'(0)} : {1'b0, len};
  endfunction

endpackage

// File: rtl/ew_state_reader_vec_skid2.sv
// Two-entry vector FIFO with a registered head and valid, shared by EW-side streams.
module vec_skid2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] tail;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + 2'd1;
    else if (pop && !push) count_d = count - 2'd1;
  end

  // Entries shift toward head on pop so the head is always the oldest beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      valid <= 1'b0;
      count <= 2'd0;
    end else begin
      count <= count_d;
      valid <= (count_d != 2'd0);
      if (pop && count == 2'd2)
        head <= tail;
      else if (push && (count == 2'd0 || (pop && count == 2'd1)))
        head <= din;
      if (push && ((pop && count == 2'd2) || (!pop && count == 2'd1)))
        tail <= din;
    end
  end

endmodule

// File: rtl/ew_state_reader.sv
// Streams a wrap-around range of EW state vectors out of the state RAM on AXIS.
// Optional clear-on-read write port enabled by defining EW_STATE_RD_CLEAR_EN.
module ew_state_reader
  import ew_state_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [S_ADDR_W-1:0] base_addr,
  input  logic [S_ADDR_W-1:0] len,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [S_ADDR_W-1:0] rd_addr,
  input  state_vec_t          rd_data,
  output logic                m_axis_TVALID,
  input  logic                m_axis_TREADY,
  output state_vec_t          m_axis_TDATA,
  output logic                m_axis_TLAST
`ifdef EW_STATE_RD_CLEAR_EN
  ,
  output logic                wr_en,
  output logic [S_ADDR_W-1:0] wr_addr,
  output state_vec_t          wr_data
`endif
);

  rd_state_e           state_q, state_d;
  logic [S_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]    issue_rem_q, issue_rem_d;
  logic [CNT_W-1:0]    beat_rem_q, beat_rem_d;
  logic                busy_d, done_d, tlast_d;
  logic                inflight_q, pop;
  logic [1:0]          fifo_cnt;
  logic [2:0]          occ, occ_next;

  assign pop      = m_axis_TVALID & m_axis_TREADY;
  assign occ      = 3'(fifo_cnt) + 3'(inflight_q);
  assign occ_next = occ - 3'(pop);
  // Reads are issued only while buffered plus in-flight beats leave room.
  assign rd_en    = (state_q == RUN) && (occ < (3'd2 + 3'(pop)));
  assign rd_addr  = addr_q;

  vec_skid2 #(.W(VEC_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (rd_data),
    .pop   (pop),
    .head  (m_axis_TDATA),
    .valid (m_axis_TVALID),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    beat_rem_d  = beat_rem_q;
    busy_d      = busy;
    done_d      = 1'b0;
    if (rd_en) begin
      addr_d      = addr_q + S_ADDR_W'(1);
      issue_rem_d = issue_rem_q - CNT_W'(1);
    end
    if (pop) beat_rem_d = beat_rem_q - CNT_W'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d     = RUN;
        addr_d      = base_addr;
        issue_rem_d = range_len(len);
        beat_rem_d  = range_len(len);
        busy_d      = 1'b1;
      end
      RUN: if (rd_en && issue_rem_q == CNT_W'(1)) state_d = DRAIN;
      DRAIN: if (pop && beat_rem_q == CNT_W'(1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Head beat is the final one when exactly one beat remains and the buffer holds it.
    tlast_d = (occ_next != 3'd0) && (beat_rem_d == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_rem_q  <= '0;
      beat_rem_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_axis_TLAST <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_rem_q  <= issue_rem_d;
      beat_rem_q   <= beat_rem_d;
      busy         <= busy_d;
      done         <= done_d;
      m_axis_TLAST <= tlast_d;
      inflight_q   <= rd_en;
    end
  end

`ifdef EW_STATE_RD_CLEAR_EN
  // Zero each location one cycle after it has been read.
  assign wr_data = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en   <= rd_en;
      wr_addr <= rd_addr;
    end
  end
`endif

endmodule

// File: tb/tb_ew_state_reader.sv
// Scoreboard bench for ew_state_reader with a behavioural 1-cycle-latency state RAM.
module tb_ew_state_reader;
  import ew_state_pkg::*;

  localparam int DEPTH = 1 << S_ADDR_W;

  typedef struct packed {
    state_vec_t data;
    logic       last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n, start, busy, done, rd_en;
  logic [S_ADDR_W-1:0] base_addr, len, rd_addr;
  state_vec_t          rd_data, m_axis_TDATA;
  logic                m_axis_TVALID, m_axis_TREADY, m_axis_TLAST;
`ifdef EW_STATE_RD_CLEAR_EN
  logic                wr_en;
  logic [S_ADDR_W-1:0] wr_addr;
  state_vec_t          wr_data;
`endif

  ew_state_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .m_axis_TVALID (m_axis_TVALID),
    .m_axis_TREADY (m_axis_TREADY),
    .m_axis_TDATA  (m_axis_TDATA),
    .m_axis_TLAST  (m_axis_TLAST)
`ifdef EW_STATE_RD_CLEAR_EN
    ,
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  exp_t       sb_q[$];
  state_vec_t exp_mem [DEPTH];
  state_vec_t ram [DEPTH];
  logic       reload = 1'b0;
  int         reload_lo = 0, reload_n = 0;

  int first_valid_k, done_k, rd_cnt, rd_stall_cnt, busy_gap, run_beats;
  bit done_at_k0, timed_out;
  int addr_log[$];

  function automatic state_vec_t init_val(input int a);
    state_vec_t v;
    for (int l = 0; l < TILE_SIZE; l++) v[l] = DATA_WIDTH'(a * 16 + l);
    return v;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 1) return !(k >= 5 && k <= 9) && (k < 10 || (k % 2) == 0);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // State RAM model: synchronous read, optional clear write, bench-side reload.
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
`ifdef EW_STATE_RD_CLEAR_EN
    if (wr_en) ram[wr_addr] <= wr_data;
`endif
    if (reload)
      for (int i = 0; i < reload_n; i++) ram[(reload_lo + i) % DEPTH] <= init_val((reload_lo + i) % DEPTH);
  end

  // Output monitor: scoreboard pops, stall stability and write-port tracking.
  logic       prev_stall = 1'b0, prev_last = 1'b0, prev_rd = 1'b0;
  state_vec_t prev_data;
  logic [S_ADDR_W-1:0] prev_addr;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_axis_TVALID), 64'(1));
        chk("stall_tdata", 64'(m_axis_TDATA), 64'(prev_data));
        chk("stall_tlast", 64'(m_axis_TLAST), 64'(prev_last));
      end
      if (m_axis_TVALID && m_axis_TREADY) begin
        tests++;
        assert (sb_q.size() != 0) else begin
          failed++;
          $error("FAIL unexpected_beat: observed data %0h expected no beat", m_axis_TDATA);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("beat_tdata", 64'(m_axis_TDATA), 64'(e.data));
          chk("beat_tlast", 64'(m_axis_TLAST), 64'(e.last));
        end
      end
      prev_stall = m_axis_TVALID && !m_axis_TREADY;
      prev_data  = m_axis_TDATA;
      prev_last  = m_axis_TLAST;
`ifdef EW_STATE_RD_CLEAR_EN
      chk("wr_en_track", 64'(wr_en), 64'(prev_rd));
      if (prev_rd) chk("wr_addr_track", 64'(wr_addr), 64'(prev_addr));
      prev_rd   = rd_en;
      prev_addr = rd_addr;
`endif
    end
  end

  task automatic reload_ram(input int lo, input int n);
    @(posedge clk); #1;
    reload = 1'b1; reload_lo = lo; reload_n = n;
    @(posedge clk); #1;
    reload = 1'b0;
    for (int i = 0; i < n; i++) exp_mem[(lo + i) % DEPTH] = init_val((lo + i) % DEPTH);
  endtask

  task automatic run_range(input int b, input int l, input int mode, input int inject_k,
                           input int inject_base, input bit exit_on_last, input int abort_beat,
                           input int max_cyc);
    int n, k, beats;
    n = (l == 0) ? DEPTH : l;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) sb_q.push_back('{data: exp_mem[(b + i) % DEPTH], last: (i == n - 1)});
`ifdef EW_STATE_RD_CLEAR_EN
    if (abort_beat == 0) for (int i = 0; i < n; i++) exp_mem[(b + i) % DEPTH] = '0;
`endif
    start = 1'b1; base_addr = S_ADDR_W'(b); len = S_ADDR_W'(l);
    m_axis_TREADY = ready_for(mode, 0);
    first_valid_k = -1; done_k = -1; rd_cnt = 0; rd_stall_cnt = 0; busy_gap = 0;
    timed_out = 1'b0; addr_log.delete(); beats = 0; k = 0;
    forever begin
      @(negedge clk);
      if (k == 0) done_at_k0 = done;
      if (k > 0 && !done && !busy) busy_gap++;
      if (rd_en) begin
        rd_cnt++;
        addr_log.push_back(int'(rd_addr));
        if (k >= 5 && k <= 9) rd_stall_cnt++;
      end
      if (m_axis_TVALID && first_valid_k < 0) first_valid_k = k;
      if (m_axis_TVALID && m_axis_TREADY) beats++;
      run_beats = beats;
      if (k > 0 && done) begin done_k = k; break; end
      if (exit_on_last && m_axis_TVALID && m_axis_TREADY && m_axis_TLAST) break;
      if (abort_beat > 0 && beats == abort_beat) break;
      if (k >= max_cyc) begin timed_out = 1'b1; break; end
      @(posedge clk); #1;
      k++;
      start = (k == inject_k);
      if (k == inject_k) begin base_addr = S_ADDR_W'(inject_base); len = S_ADDR_W'(3); end
      m_axis_TREADY = ready_for(mode, k);
    end
    tests++;
    assert (!timed_out) else begin
      failed++;
      $error("FAIL run_timeout base=%0d len=%0d: observed %0d cycles expected completion", b, l, k);
    end
  endtask

  task automatic chk_addrs(input string tag, input int b, input int n);
    chk({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(n));
    for (int i = 0; i < n && i < addr_log.size(); i++)
      chk({tag, "_rd_addr"}, 64'(addr_log[i]), 64'((b + i) % DEPTH));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
    chk({tag, "_tvalid"}, 64'(m_axis_TVALID), 64'(0));
    chk({tag, "_tlast"}, 64'(m_axis_TLAST), 64'(0));
    chk({tag, "_tdata"}, 64'(m_axis_TDATA), 64'(0));
`ifdef EW_STATE_RD_CLEAR_EN
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idle_hits;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_axis_TREADY = 1'b0;
    reload_ram(0, DEPTH);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic range from address 0 with TREADY held high.
    run_range(0, 4, 0, -1, 0, 1'b0, 0, 50);
    chk("t1_first_valid", 64'(first_valid_k), 64'(3));
    chk("t1_done_cycle", 64'(done_k), 64'(7));
    chk("t1_busy_gap", 64'(busy_gap), 64'(0));
    chk_addrs("t1", 0, 4);
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'(0));

    // Wrap-around range; next range starts in the cycle right after the last handshake.
    run_range(62, 4, 0, -1, 0, 1'b1, 0, 50);
    chk("t2_first_valid", 64'(first_valid_k), 64'(3));
    chk_addrs("t2", 62, 4);

    // Backpressure: stalled cycles 5-9 then alternating ready.
    run_range(40, 8, 1, -1, 0, 1'b0, 0, 80);
    chk("t3_b2b_done", 64'(done_at_k0), 64'(1));
    chk("t3_first_valid", 64'(first_valid_k), 64'(3));
    chk("t3_rd_during_stall", 64'(rd_stall_cnt), 64'(0));
    chk("t3_done_cycle", 64'(done_k), 64'(21));
    chk_addrs("t3", 40, 8);

    // start while running must be ignored.
    run_range(20, 6, 0, 4, 10, 1'b0, 0, 50);
    chk("t4_done_cycle", 64'(done_k), 64'(9));
    chk_addrs("t4", 20, 6);
    idle_hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || m_axis_TVALID || rd_en) idle_hits++;
    end
    chk("t4_idle_after", 64'(idle_hits), 64'(0));

    // Reset in the middle of a range, then a fresh short range.
    run_range(30, 8, 0, -1, 0, 1'b0, 3, 50);
    chk("t5_abort_beats", 64'(run_beats), 64'(3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_reset_outputs("midreset");
    reload_ram(30, 8);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_en || m_axis_TVALID || busy) idle_hits++;
    end
    chk("t5_quiet_after_reset", 64'(idle_hits), 64'(0));
    run_range(5, 2, 0, -1, 0, 1'b0, 0, 50);
    chk("t5_beats", 64'(run_beats), 64'(2));
    chk("t5_done_cycle", 64'(done_k), 64'(5));
    chk_addrs("t5", 5, 2);

    // len=0 covers the whole memory, starting mid-range to exercise wrap.
    run_range(17, 0, 0, -1, 0, 1'b0, 0, 200);
    chk("t6_beats", 64'(run_beats), 64'(DEPTH));
    chk("t6_done_cycle", 64'(done_k), 64'(DEPTH + 3));
    chk("t6_busy_gap", 64'(busy_gap), 64'(0));
    chk_addrs("t6", 17, DEPTH);

    // Reread of the first range: zeros when clear-on-read is built in.
    run_range(0, 4, 0, -1, 0, 1'b0, 0, 50);
    chk("t7_done_cycle", 64'(done_k), 64'(7));

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
